// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register index width
// and the grouped enable/flush vectors driven into the pipeline registers.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_BUSY  = 2'd2,
    ST_ERR      = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } hz_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } hz_fl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: the ID instruction reads a register that the load in EX
// has not produced yet. Writes to x0 never create a dependency.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_is_load,
  output logic             o_load_use
);

  logic w_rd_nz;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_rd_nz    = |i_ex_rd;
  assign w_hit_rs1  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_is_load & w_rd_nz & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// squashes, data-memory wait states with timeout, multi-cycle EX ops.
module pipe_hazard_ctrl #(
  parameter int REG_W       = pipe_hazard_ctrl_pkg::REG_W,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_en,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stall_cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  import pipe_hazard_ctrl_pkg::*;

  localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic [TCNT_W-1:0] w_tcnt_inc;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_load_use;
  logic              w_mem_stall;
  hz_en_t            w_en;
  hz_fl_t            w_fl;
  hz_en_t            w_run_en;
  hz_fl_t            w_run_fl;
  hz_state_e         w_run_nxt;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .i_id_rs1    (id_rs1),
    .i_id_rs2    (id_rs2),
    .i_id_use_rs1(id_use_rs1),
    .i_id_use_rs2(id_use_rs2),
    .i_ex_rd     (ex_rd),
    .i_ex_is_load(ex_is_load),
    .o_load_use  (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_tcnt_inc  = r_tcnt + TCNT_W'(1);

  // Normal-flow decision, shared by RUN and by the cycle memory becomes ready
  always_comb begin
    w_run_en  = hz_en_t'(5'b11111);
    w_run_fl  = hz_fl_t'(3'b000);
    w_run_nxt = ST_RUN;
    if (ex_mc_start) begin
      w_run_en  = hz_en_t'(5'b00011);
      w_run_fl  = hz_fl_t'(3'b001);
      w_run_nxt = ST_MC_BUSY;
    end else if (ex_branch_taken) begin
      w_run_fl  = hz_fl_t'(3'b110);
    end else if (w_load_use) begin
      w_run_en  = hz_en_t'(5'b00111);
      w_run_fl  = hz_fl_t'(3'b010);
    end
  end

  always_comb begin
    w_en        = hz_en_t'(5'b00000);
    w_fl        = hz_fl_t'(3'b000);
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
          w_tcnt_nxt  = TCNT_W'(1);
        end else begin
          w_en        = w_run_en;
          w_fl        = w_run_fl;
          w_state_nxt = w_run_nxt;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_en        = w_run_en;
          w_fl        = w_run_fl;
          w_state_nxt = w_run_nxt;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = w_tcnt_inc;
          if (w_tcnt_inc == TCNT_W'(MEM_TIMEOUT)) w_state_nxt = ST_ERR;
        end
      end
      ST_MC_BUSY: begin
        // A mem-stalled cycle freezes everything, including acceptance of done
        if (!w_mem_stall) begin
          if (ex_mc_done) begin
            w_en        = hz_en_t'(5'b11111);
            w_state_nxt = ST_RUN;
          end else begin
            w_en = hz_en_t'(5'b00011);
            w_fl = hz_fl_t'(3'b001);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_tcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_mem_err <= r_mem_err | (w_state_nxt == ST_ERR);
    end
  end

  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (!w_en.pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_en        = rst & w_en.pc;
  assign if_id_en     = rst & w_en.if_id;
  assign id_ex_en     = rst & w_en.id_ex;
  assign ex_mem_en    = rst & w_en.ex_mem;
  assign mem_wb_en    = rst & w_en.mem_wb;
  assign if_id_flush  = rst & w_fl.if_id;
  assign id_ex_flush  = rst & w_fl.id_ex;
  assign ex_mem_flush = rst & w_fl.ex_mem;
  assign mem_err      = r_mem_err;
  assign state        = r_state;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage CPU pipeline. Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs come from decode, EX and MEM stage status. Handles four cases: load-use hazards, taken-branch squashes, data-memory wait states with timeout, and multi-cycle EX operations such as mul/div. Keeps a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register index width
CNT_W, 16, stall counter width
MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before error (>=2)

Ports:
clk_en  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low
id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  source register actually read
ex_rd  in  REG_W  destination register of the instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_mc_start  in  1  EX holds a multi-cycle op; first cycle
ex_mc_done  in  1  multi-cycle result ready; level, held until accepted
mem_req  in  1  MEM stage performs a data access
mem_ready  in  1  data memory ack
stall_cnt_clr  in  1  synchronous clear of stall_cnt
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (zero) on the next edge
mem_err  out  1  sticky memory-timeout error
state  out  2  debug: RUN=0, MEM_WAIT=1, MC_BUSY=2, ERR=3
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, timeout counter=0, stall_cnt=0, mem_err=0.
  - All enables and all flushes forced to 0 combinationally.
- Enables and flushes are combinational from state and inputs, so they act on the same edge. State and counters update on posedge clk_en.
- Definitions:
  - load_use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - mem_stall = mem_req & ~mem_ready.
- Priority within a cycle: ERR > mem_stall > multi-cycle > branch > load_use > normal.
- RUN:
  - mem_stall: all enables 0, no flushes; next state MEM_WAIT, timeout counter=1.
  - ex_mc_start: pc/if_id/id_ex en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1; next state MC_BUSY.
  - ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1. load_use is ignored because the ID instruction is squashed.
  - load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1; ex_mem/mem_wb en=1. The stall lasts one cycle; it clears naturally because the load advances.
  - Otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - All enables 0 while mem_ready=0; the timeout counter increments.
  - mem_ready=1: apply the RUN rules this cycle (excluding mem_stall); next state RUN (or MC_BUSY per the RUN rules); counter cleared.
  - Counter reaches MEM_TIMEOUT with mem_ready=0: next state ERR, mem_err=1. If mem_ready=1 on that same cycle, ready wins.
- MC_BUSY:
  - pc/if_id/id_ex en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1 (drain older instructions).
  - mem_stall in MC_BUSY: all enables 0, stay in MC_BUSY. ex_mc_done is not accepted in a mem-stalled cycle.
  - ex_mc_done=1 and not mem_stall: all enables 1, no flushes; next state RUN.
- ERR: all enables 0, flushes 0, mem_err=1. Only rst exits.
- stall_cnt:
  - +1 each cycle with pc_en=0 and rst=1; saturates at all ones.
  - stall_cnt_clr has priority over increment.

Decomposition:
- Shared pipeline package holds: the state encoding constants (RUN/MEM_WAIT/MC_BUSY/ERR) and REG_W, reused by the pipeline registers and the debug bus.
- One sub-module: hazard_detect, purely combinational, computes load_use from ID/EX fields. The FSM, timeout counter and stall counter stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0→1.
- Hazard on x0: ex_rd=0, id_rs1=0 with load → no stall, all enables 1.
- Branch and load-use in the same cycle → if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait:
  - mem_req=1, mem_ready=0 for 3 cycles then 1 → all enables 0 for 3 cycles, state=1; enables 1 on the ready cycle, then state=0; stall_cnt +3.
  - MEM_TIMEOUT=4, mem_ready held 0 → state=3 and mem_err=1 after 4 wait cycles; enables stay 0 until rst.
- Multi-cycle op: ex_mc_start, ex_mc_done after 5 cycles → ex_mem_flush=1 and pc_en=0 for 6 cycles, then RUN. A mem_stall injected mid-op delays acceptance of done by the stall length.
- Mid-op reset: rst low during MC_BUSY → outputs 0 immediately, state=0, stall_cnt=0, mem_err=0.
